pipe_stage_skid: RTL and testbench
==================================

// Module: pipe_stage_skid
// PURPOSE
//  Parametrised inter-stage pipeline register (IF/ID, ID/EX, ...) with valid/ready handshake.
//  Carries one payload word plus its NPC; supports flush (branch/jump squash) and downstream
//  backpressure in place of a bare stall input. Sits between any two CPU stages; the optional
//  skid slot registers the upstream ready so no combinational ready path crosses the stage.
// PARAMETERS
//  DATA_W         32     payload width (instruction or bundled control word)
//  NPC_W          32     next-PC field width
//  BUBBLE_VAL     0      payload driven when out_dn_valid=0 (NOP encoding); DATA_W bits
//  CLEAR_ON_FLUSH 1      1: flush also loads BUBBLE_VAL/0 into data regs; 0: flush clears valid only
// PORTS
//  in_clk         in   1       clock, rising edge
//  in_rst_n       in   1       asynchronous reset, active-low
//  in_flush       in   1       squash all held and incoming beats (synchronous)
//  in_up_valid    in   1       upstream beat valid
//  out_up_ready   out  1       stage accepts a beat this cycle
//  in_up_data     in   DATA_W  upstream payload
//  in_up_npc      in   NPC_W   upstream NPC
//  out_dn_valid   out  1       beat presented downstream
//  in_dn_ready    in   1       downstream accepts (0 = stall)
//  out_dn_data    out  DATA_W  payload to next stage
//  out_dn_npc     out  NPC_W   NPC to next stage
// BEHAVIOUR
//  - Reset (in_rst_n=0, async): out_dn_valid=0, out_dn_data=BUBBLE_VAL, out_dn_npc=0, skid empty,
//    out_up_ready=1 from the first cycle after deassertion.
//  - Accept = in_up_valid & out_up_ready; Retire = out_dn_valid & in_dn_ready. Strict in-order.
//  - Latency: accepted beat appears on out_dn_* the next cycle (1 cycle, no bypass).
//  - While out_dn_valid=1 & in_dn_ready=0, out_dn_data/out_dn_npc hold stable.
//  - When out_dn_valid=0, out_dn_data=BUBBLE_VAL and out_dn_npc=0.
//  - in_flush has highest priority: next cycle all entries invalid, beat offered in the flush
//    cycle is discarded (not accepted, even if out_up_ready=1), state -> EMPTY,
//    out_up_ready=1. Flush wins over simultaneous accept/retire; a retire in the flush cycle
//    still counts downstream (flush does not recall an already-handed-off beat).
//  - Without skid: out_up_ready = ~out_dn_valid | in_dn_ready (combinational); states EMPTY/FULL.
//  - Reset mid-transfer discards all beats; no partial state survives.
// CONFIGURATION
//  Macro PIPE_STAGE_SKID_EN:
//   defined   - 2-entry (main + skid); out_up_ready is a flop = (state != SKID).
//     EMPTY: accept -> FULL.
//     FULL : accept&retire -> FULL (main<=in); accept&~retire -> SKID (skid<=in);
//            ~accept&retire -> EMPTY; else hold.
//     SKID : retire -> FULL (main<=skid, ready<=1); else hold; no accept possible.
//     Full sustained throughput 1 beat/cycle; ready deasserts 1 cycle after a stall begins.
//   undefined - single entry, combinational ready as above; no skid regs synthesised.
// STRUCTURE
//  - Package pipe_pkg: state localparams ST_EMPTY/ST_FULL/ST_SKID (2-bit), NOP_INSN=32'h0
//    (default for BUBBLE_VAL), shared by all pipe_* stage registers.
//  - Sub-module pipe_skid_buf (skid data+npc regs, load/clear), instantiated only under
//    PIPE_STAGE_SKID_EN; top holds main regs, state FSM, flush and ready logic.
// TESTING
//  1 Reset: hold in_rst_n=0 with in_up_valid=1, data=32'h1234_5678 -> out_dn_valid=0,
//    out_dn_data=0, out_dn_npc=0; release -> out_up_ready=1.
//  2 Stream: 8 beats data=i, npc=4*i, in_dn_ready=1 -> out_dn_* match 1 cycle later,
//    1 beat/cycle, no drop/dup.
//  3 Backpressure: after beat A=32'hA, B=32'hB drop in_dn_ready for 3 cycles -> A held
//    stable; with SKID_EN B held in skid, out_up_ready=0, B emitted after A; without, B
//    refused until ready.
//  4 Flush: in SKID state pulse in_flush with in_up_valid=1 C=32'hC -> next cycle
//    out_dn_valid=0, out_dn_data=BUBBLE_VAL, C never appears, out_up_ready=1.
//  5 Flush+retire same cycle: out_dn_valid=1, in_dn_ready=1, in_flush=1 -> beat counted
//    once downstream, stage EMPTY next cycle.
//  6 Async reset mid-stall (state SKID): drop in_rst_n between edges -> outputs clear
//    immediately, no stale beat after release.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipe_* inter-stage pipeline registers.
// Holds the stage occupancy encoding and the default bubble (NOP) payload.
package pipe_pkg;

    // Stage occupancy: no beat, one beat in main, main plus one beat in skid.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } pipe_state_e;

    // Payload driven downstream when no beat is presented.
    localparam logic [31:0] NOP_INSN = 32'h0000_0000;

endpackage

// File: rtl/pipe_skid_buf.sv
// Skid slot for pipe_stage_skid: one payload word plus its NPC.
// The slot catches the beat accepted in the cycle the downstream stalls,
// so the upstream ready can come from a flop.
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int                 DATA_W     = 32,
    parameter int                 NPC_W      = 32,
    parameter logic [DATA_W-1:0]  BUBBLE_VAL = DATA_W'(NOP_INSN)
) (
    input  logic              in_clk,
    input  logic              in_rst_n,
    input  logic              in_load,
    input  logic              in_clear,
    input  logic [DATA_W-1:0] in_data,
    input  logic [NPC_W-1:0]  in_npc,
    output logic [DATA_W-1:0] out_data,
    output logic [NPC_W-1:0]  out_npc
);

    logic [DATA_W-1:0] data_q, data_d;
    logic [NPC_W-1:0]  npc_q, npc_d;

    // Clear wins over load; otherwise the slot holds its contents.
    always_comb begin
        data_d = data_q;
        npc_d  = npc_q;
        if (in_clear) begin
            data_d = BUBBLE_VAL;
            npc_d  = '0;
        end else if (in_load) begin
            data_d = in_data;
            npc_d  = in_npc;
        end
    end

    // Slot storage, emptied to the bubble value on reset.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            data_q <= BUBBLE_VAL;
            npc_q  <= '0;
        end else begin
            data_q <= data_d;
            npc_q  <= npc_d;
        end
    end

    assign out_data = data_q;
    assign out_npc  = npc_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshake, flush and backpressure.
// Optional feature macro: PIPE_STAGE_SKID_EN
//   defined   - two entries (main + skid), upstream ready comes from a flop.
//   undefined - single entry, upstream ready is ~out_dn_valid | in_dn_ready.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int                 DATA_W         = 32,
    parameter int                 NPC_W          = 32,
    parameter logic [DATA_W-1:0]  BUBBLE_VAL     = DATA_W'(NOP_INSN),
    parameter bit                 CLEAR_ON_FLUSH = 1'b1
) (
    input  logic              in_clk,
    input  logic              in_rst_n,
    input  logic              in_flush,
    input  logic              in_up_valid,
    output logic              out_up_ready,
    input  logic [DATA_W-1:0] in_up_data,
    input  logic [NPC_W-1:0]  in_up_npc,
    output logic              out_dn_valid,
    input  logic              in_dn_ready,
    output logic [DATA_W-1:0] out_dn_data,
    output logic [NPC_W-1:0]  out_dn_npc
);

    pipe_state_e       state_q, state_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [NPC_W-1:0]  main_npc_q, main_npc_d;
    logic              dn_valid;
    logic              accept;
    logic              retire;

    assign dn_valid = (state_q != ST_EMPTY);
    assign retire   = dn_valid & in_dn_ready;
    // A beat offered during a flush is never taken, even with ready high.
    assign accept   = in_up_valid & out_up_ready & ~in_flush;

`ifdef PIPE_STAGE_SKID_EN
    logic              ready_q, ready_d;
    logic              skid_load;
    logic              skid_clear;
    logic [DATA_W-1:0] skid_data;
    logic [NPC_W-1:0]  skid_npc;

    assign out_up_ready = ready_q;

    pipe_skid_buf #(
        .DATA_W     (DATA_W),
        .NPC_W      (NPC_W),
        .BUBBLE_VAL (BUBBLE_VAL)
    ) u_skid (
        .in_clk   (in_clk),
        .in_rst_n (in_rst_n),
        .in_load  (skid_load),
        .in_clear (skid_clear),
        .in_data  (in_up_data),
        .in_npc   (in_up_npc),
        .out_data (skid_data),
        .out_npc  (skid_npc)
    );

    // Occupancy FSM: flush empties everything, a stalled accept spills into the skid slot.
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_npc_d  = main_npc_q;
        skid_load   = 1'b0;
        skid_clear  = 1'b0;
        if (in_flush) begin
            state_d = ST_EMPTY;
            if (CLEAR_ON_FLUSH) begin
                main_data_d = BUBBLE_VAL;
                main_npc_d  = '0;
                skid_clear  = 1'b1;
            end
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d     = ST_FULL;
                        main_data_d = in_up_data;
                        main_npc_d  = in_up_npc;
                    end
                end
                ST_FULL: begin
                    if (accept && retire) begin
                        main_data_d = in_up_data;
                        main_npc_d  = in_up_npc;
                    end else if (accept) begin
                        state_d   = ST_SKID;
                        skid_load = 1'b1;
                    end else if (retire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (retire) begin
                        state_d     = ST_FULL;
                        main_data_d = skid_data;
                        main_npc_d  = skid_npc;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
        ready_d = (state_d != ST_SKID);
    end

    // Registered upstream ready so no combinational path crosses the stage.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            ready_q <= 1'b1;
        end else begin
            ready_q <= ready_d;
        end
    end
`else
    assign out_up_ready = ~dn_valid | in_dn_ready;

    // Single-entry FSM: flush empties, accept fills (also on retire), lone retire empties.
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_npc_d  = main_npc_q;
        if (in_flush) begin
            state_d = ST_EMPTY;
            if (CLEAR_ON_FLUSH) begin
                main_data_d = BUBBLE_VAL;
                main_npc_d  = '0;
            end
        end else if (accept) begin
            state_d     = ST_FULL;
            main_data_d = in_up_data;
            main_npc_d  = in_up_npc;
        end else if (retire) begin
            state_d = ST_EMPTY;
        end
    end
`endif

    // Main entry and occupancy registers; reset drops any beat in flight.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q     <= ST_EMPTY;
            main_data_q <= BUBBLE_VAL;
            main_npc_q  <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_npc_q  <= main_npc_d;
        end
    end

    // Downstream sees the bubble whenever nothing valid is presented, whatever the regs hold.
    assign out_dn_valid = dn_valid;
    assign out_dn_data  = dn_valid ? main_data_q : BUBBLE_VAL;
    assign out_dn_npc   = dn_valid ? main_npc_q  : '0;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid (default parameters).
// Honours PIPE_STAGE_SKID_EN to select the matching expected behaviour.
module tb_pipe_stage_skid;

    localparam logic [31:0] BUBBLE = 32'h0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        up_valid;
    logic        up_ready;
    logic [31:0] up_data;
    logic [31:0] up_npc;
    logic        dn_valid;
    logic        dn_ready;
    logic [31:0] dn_data;
    logic [31:0] dn_npc;

    typedef struct {
        logic [31:0] data;
        logic [31:0] npc;
    } beat_t;

    typedef struct {
        logic        flush;
        logic        uv;
        logic        dr;
        logic [31:0] data;
        logic [31:0] npc;
        logic        e_valid;
        logic        e_ready;
        logic [31:0] e_data;
        logic [31:0] e_npc;
    } vec_t;

    beat_t sb_q[$];
    vec_t  tbl[$];
    int    checks   = 0;
    int    failures = 0;
    int    dut_ret  = 0;
    int    ret_base = 0;
`ifdef PIPE_STAGE_SKID_EN
    bit    model_ready_q = 1'b1;
`endif

    pipe_stage_skid dut (
        .in_clk       (clk),
        .in_rst_n     (rst_n),
        .in_flush     (flush),
        .in_up_valid  (up_valid),
        .out_up_ready (up_ready),
        .in_up_data   (up_data),
        .in_up_npc    (up_npc),
        .out_dn_valid (dn_valid),
        .in_dn_ready  (dn_ready),
        .out_dn_data  (dn_data),
        .out_dn_npc   (dn_npc)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mkVec(input logic f, input logic uv, input logic dr,
                                   input logic [31:0] d, input logic [31:0] n,
                                   input logic ev, input logic er,
                                   input logic [31:0] ed, input logic [31:0] en);
        vec_t v;
        v.flush = f;  v.uv = uv;  v.dr = dr;  v.data = d;  v.npc = n;
        v.e_valid = ev;  v.e_ready = er;  v.e_data = ed;  v.e_npc = en;
        return v;
    endfunction

    task automatic modelReset();
        sb_q.delete();
`ifdef PIPE_STAGE_SKID_EN
        model_ready_q = 1'b1;
`endif
    endtask

    // Drive one cycle of inputs at the falling edge and let them settle.
    task automatic applyStimulus(input logic f, input logic uv, input logic [31:0] d,
                                 input logic [31:0] n, input logic dr);
        @(negedge clk);
        flush    = f;
        up_valid = uv;
        up_data  = d;
        up_npc   = n;
        dn_ready = dr;
        #1;
    endtask

    // Compare against the scoreboard, then advance it by this cycle's handshakes.
    task automatic checkOutput(input string tag);
        bit          exp_valid;
        bit          exp_ready;
        logic [31:0] exp_d;
        logic [31:0] exp_n;
        exp_valid = (sb_q.size() > 0);
`ifdef PIPE_STAGE_SKID_EN
        exp_ready = model_ready_q;
`else
        exp_ready = !exp_valid || dn_ready;
`endif
        exp_d = exp_valid ? sb_q[0].data : BUBBLE;
        exp_n = exp_valid ? sb_q[0].npc  : 32'h0;
        checkVal({tag, ".valid"}, 64'(dn_valid), 64'(exp_valid));
        checkVal({tag, ".ready"}, 64'(up_ready), 64'(exp_ready));
        checkVal({tag, ".data"},  64'(dn_data),  64'(exp_d));
        checkVal({tag, ".npc"},   64'(dn_npc),   64'(exp_n));
        if (dn_valid && dn_ready) dut_ret++;
        if (exp_valid && dn_ready) void'(sb_q.pop_front());
        if (flush) begin
            sb_q.delete();
        end else if (up_valid && exp_ready) begin
            beat_t b;
            b.data = up_data;
            b.npc  = up_npc;
            sb_q.push_back(b);
        end
`ifdef PIPE_STAGE_SKID_EN
        model_ready_q = (sb_q.size() < 2);
`endif
    endtask

    task automatic cycle(input string tag, input logic f, input logic uv,
                         input logic [31:0] d, input logic [31:0] n, input logic dr);
        applyStimulus(f, uv, d, n, dr);
        checkOutput(tag);
        @(posedge clk);
    endtask

    task automatic checkRetired(input string tag, input int exp);
        checkVal(tag, 64'(dut_ret - ret_base), 64'(exp));
        ret_base = dut_ret;
    endtask

    task automatic fillTable();
        tbl.delete();
`ifdef PIPE_STAGE_SKID_EN
        tbl.push_back(mkVec(0, 1, 1, 32'hA, 32'h28, 0, 1, 32'h0, 32'h0));
        tbl.push_back(mkVec(0, 1, 0, 32'hB, 32'h2C, 1, 1, 32'hA, 32'h28));
        tbl.push_back(mkVec(0, 1, 0, 32'hD, 32'h34, 1, 0, 32'hA, 32'h28));
        tbl.push_back(mkVec(0, 1, 0, 32'hD, 32'h34, 1, 0, 32'hA, 32'h28));
        tbl.push_back(mkVec(0, 1, 1, 32'hD, 32'h34, 1, 0, 32'hA, 32'h28));
        tbl.push_back(mkVec(0, 1, 1, 32'hD, 32'h34, 1, 1, 32'hB, 32'h2C));
        tbl.push_back(mkVec(0, 0, 1, 32'h0, 32'h0,  1, 1, 32'hD, 32'h34));
        tbl.push_back(mkVec(0, 0, 1, 32'h0, 32'h0,  0, 1, 32'h0, 32'h0));
`else
        tbl.push_back(mkVec(0, 1, 1, 32'hA, 32'h28, 0, 1, 32'h0, 32'h0));
        tbl.push_back(mkVec(0, 1, 0, 32'hB, 32'h2C, 1, 0, 32'hA, 32'h28));
        tbl.push_back(mkVec(0, 1, 0, 32'hB, 32'h2C, 1, 0, 32'hA, 32'h28));
        tbl.push_back(mkVec(0, 1, 0, 32'hB, 32'h2C, 1, 0, 32'hA, 32'h28));
        tbl.push_back(mkVec(0, 1, 1, 32'hB, 32'h2C, 1, 1, 32'hA, 32'h28));
        tbl.push_back(mkVec(0, 0, 1, 32'h0, 32'h0,  1, 1, 32'hB, 32'h2C));
        tbl.push_back(mkVec(0, 0, 1, 32'h0, 32'h0,  0, 1, 32'h0, 32'h0));
`endif
    endtask

    initial begin
        rst_n    = 1'b0;
        flush    = 1'b0;
        up_valid = 1'b1;
        up_data  = 32'h1234_5678;
        up_npc   = 32'h0000_0100;
        dn_ready = 1'b0;
        modelReset();

        // 1: reset holds everything empty even with a valid beat offered
        repeat (2) @(posedge clk);
        #2;
        checkVal("reset.valid", 64'(dn_valid), 64'(0));
        checkVal("reset.data",  64'(dn_data),  64'(BUBBLE));
        checkVal("reset.npc",   64'(dn_npc),   64'(0));
        @(negedge clk);
        rst_n    = 1'b1;
        up_valid = 1'b0;
        dn_ready = 1'b1;
        #1;
        checkVal("reset.ready", 64'(up_ready), 64'(1));

        // 2: back-to-back stream at full rate
        $display("[TB] stream");
        for (int i = 0; i < 8; i++)
            cycle($sformatf("stream%0d", i), 0, 1, 32'(i), 32'(4 * i), 1);
        cycle("stream_tail0", 0, 0, 32'h0, 32'h0, 1);
        cycle("stream_tail1", 0, 0, 32'h0, 32'h0, 1);
        checkRetired("stream.retired", 8);

        // 3: backpressure from the vector table
        $display("[TB] backpressure table");
        fillTable();
        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i].flush, tbl[i].uv, tbl[i].data, tbl[i].npc, tbl[i].dr);
            checkVal($sformatf("tbl%0d.valid", i), 64'(dn_valid), 64'(tbl[i].e_valid));
            checkVal($sformatf("tbl%0d.ready", i), 64'(up_ready), 64'(tbl[i].e_ready));
            checkVal($sformatf("tbl%0d.data", i),  64'(dn_data),  64'(tbl[i].e_data));
            checkVal($sformatf("tbl%0d.npc", i),   64'(dn_npc),   64'(tbl[i].e_npc));
            checkOutput($sformatf("tbl%0d.sb", i));
            @(posedge clk);
        end
`ifdef PIPE_STAGE_SKID_EN
        checkRetired("tbl.retired", 3);
`else
        checkRetired("tbl.retired", 2);
`endif

        // 4: flush while stalled and full, with a new beat on offer
        $display("[TB] flush while stalled");
        cycle("fl_x", 0, 1, 32'h21, 32'h84, 0);
        cycle("fl_y", 0, 1, 32'h22, 32'h88, 0);
        cycle("fl_c", 1, 1, 32'hC,  32'h30, 0);
        applyStimulus(0, 0, 32'h0, 32'h0, 1);
        checkVal("flush.valid", 64'(dn_valid), 64'(0));
        checkVal("flush.data",  64'(dn_data),  64'(BUBBLE));
        checkVal("flush.ready", 64'(up_ready), 64'(1));
        checkOutput("fl_after");
        @(posedge clk);
        for (int i = 0; i < 3; i++)
            cycle($sformatf("fl_idle%0d", i), 0, 0, 32'h0, 32'h0, 1);
        checkRetired("flush.retired", 0);

        // 5: flush coincides with a retire and an offered beat while ready is high
        $display("[TB] flush with retire");
        cycle("fr_e", 0, 1, 32'hE, 32'h38, 1);
        applyStimulus(1, 1, 32'hF, 32'h3C, 1);
        checkVal("fr.ready_in_flush", 64'(up_ready), 64'(1));
        checkOutput("fr_flush");
        @(posedge clk);
        applyStimulus(0, 0, 32'h0, 32'h0, 1);
        checkVal("fr.valid_after", 64'(dn_valid), 64'(0));
        checkOutput("fr_after");
        @(posedge clk);
        for (int i = 0; i < 2; i++)
            cycle($sformatf("fr_idle%0d", i), 0, 0, 32'h0, 32'h0, 1);
        checkRetired("flush_retire.retired", 1);

        // 6: asynchronous reset in the middle of a stall
        $display("[TB] async reset mid-stall");
        cycle("ar_p", 0, 1, 32'h31, 32'hC4, 0);
        cycle("ar_q", 0, 1, 32'h32, 32'hC8, 0);
        #3;
        rst_n = 1'b0;
        #1;
        checkVal("areset.valid", 64'(dn_valid), 64'(0));
        checkVal("areset.data",  64'(dn_data),  64'(BUBBLE));
        checkVal("areset.npc",   64'(dn_npc),   64'(0));
        modelReset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        up_valid = 1'b0;
        dn_ready = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 3; i++)
            cycle($sformatf("ar_idle%0d", i), 0, 0, 32'h0, 32'h0, 1);
        checkRetired("areset.retired", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
